hazard_ctrl: RTL

Pipeline hazard and stall controller for the five-stage ARM core. It drives the `flush`/`freeze` inputs of the IF/ID and ID/EX pipeline registers and the forwarding mux selects in EX. It decides per cycle whether to stall on a load-use dependency, flush on a taken branch, or freeze the whole pipe while a multi-cycle SRAM access is outstanding. It also keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/arm_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the five-stage ARM core.
// Hazard FSM states, forwarding select encodings, register index width.
package arm_pkg;

  localparam int REG_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding mux select for one EX source operand.
// The younger MEM result has priority over the WB value.
module fwd_sel
  import arm_pkg::*;
(
  input  logic             fwd_en_i,
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic [REG_W-1:0] wb_dest_i,
  input  logic             wb_wb_en_i,
  output logic [1:0]       sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (!fwd_en_i)
      sel_o = FWD_RF;
    else if (mem_wb_en_i && mem_dest_i == src_i)
      sel_o = FWD_MEM;
    else if (wb_wb_en_i && wb_dest_i == src_i)
      sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and SRAM-wait freeze control,
// plus forwarding selects, perf counters and a sticky timeout flag.
module hazard_ctrl
  import arm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             exe_b,
  input  logic [REG_W-1:0] exe_src1,
  input  logic [REG_W-1:0] exe_src2,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  output logic             freeze_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_pipe,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic       frz, fpc, fif, fid;
  logic       hz1, hz2, hazard;
  logic [1:0] s1, s2;

  // Without forwarding every in-flight producer is a RAW hazard.
  assign hz1 = id_src1_used &&
    ((exe_wb_en && exe_dest == id_src1 &&
      (exe_mem_r_en || !fwd_en)) ||
     (!fwd_en && mem_wb_en && mem_dest == id_src1));
  assign hz2 = id_two_src &&
    ((exe_wb_en && exe_dest == id_src2 &&
      (exe_mem_r_en || !fwd_en)) ||
     (!fwd_en && mem_wb_en && mem_dest == id_src2));
  assign hazard = hz1 || hz2;

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    frz     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !sram_ready) begin
          state_d = MEM_WAIT;
          to_d    = '0;
          frz     = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) state_d = RUN;
        else            frz     = 1'b1;
        if (to_q != TO_MAX) to_d = to_q + 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign err_d = err_q || (to_d == TO_MAX);

  always_comb begin
    fpc = 1'b0;
    fif = 1'b0;
    fid = 1'b0;
    if (!frz) begin
      if (exe_b) begin
        fif = 1'b1;
        fid = 1'b1;
      end else if (hazard) begin
        fpc = 1'b1;
        fid = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((fpc || frz) && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (fif && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      to_q    <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  fwd_sel u_sel1 (
    .fwd_en_i    (fwd_en),
    .src_i       (exe_src1),
    .mem_dest_i  (mem_dest),
    .mem_wb_en_i (mem_wb_en),
    .wb_dest_i   (wb_dest),
    .wb_wb_en_i  (wb_wb_en),
    .sel_o       (s1)
  );

  fwd_sel u_sel2 (
    .fwd_en_i    (fwd_en),
    .src_i       (exe_src2),
    .mem_dest_i  (mem_dest),
    .mem_wb_en_i (mem_wb_en),
    .wb_dest_i   (wb_dest),
    .wb_wb_en_i  (wb_wb_en),
    .sel_o       (s2)
  );

  // Everything is held low while reset is asserted.
  assign freeze_pc   = rst & fpc;
  assign flush_if_id = rst & fif;
  assign flush_id_ex = rst & fid;
  assign freeze_pipe = rst & frz;
  assign sel_src1    = {2{rst}} & s1;
  assign sel_src2    = {2{rst}} & s2;
  assign mem_err     = rst & err_q;
  assign stall_cnt   = {CNT_W{rst}} & stall_q;
  assign flush_cnt   = {CNT_W{rst}} & flush_q;

endmodule
